// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the
// data memory. The arbiter uses the slave view; the surrounding
// environment (CPU MEM stage, loader/debug port, memory) uses the master view.
interface dmem_arbiter_if;
    // Requester A (CPU MEM stage)
    logic        a_req;
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_ack;
    logic [31:0] a_rdata;
    logic        a_err;
    // Requester B (loader/debug port)
    logic        b_req;
    logic        b_we;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic        b_ack;
    logic [31:0] b_rdata;
    logic        b_err;
    // Data memory side
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [31:0] mem_rdata;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata, a_err,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata, b_err,
        output mem_addr, mem_wdata, mem_memwrite, mem_memread,
        input  mem_rdata
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata, a_err,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata, b_err,
        input  mem_addr, mem_wdata, mem_memwrite, mem_memread,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each transaction takes IDLE -> ACCESS -> RESP; the winner's command is
// captured at grant so requesters are free once they see their ack.
module dmem_arbiter #(
    parameter int MEM_AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_b_q;      // 1 = B won the most recent grant
    logic        owner_b_q;     // requester owning the transaction in flight
    logic        cmd_we_q;
    logic [31:0] cmd_addr_q;
    logic [31:0] cmd_wdata_q;
    logic        cmd_err_q;
    logic [31:0] rdata_q;

    logic        any_req;
    logic        grant_b;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    // Misaligned word access or address beyond the memory window.
    function automatic logic addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr[31:MEM_AW] != '0);
    endfunction

    assign any_req   = bus.a_req | bus.b_req;
    // B wins when alone, or on a tie when A had the last grant.
    assign grant_b   = bus.b_req & (~bus.a_req | ~last_b_q);
    assign sel_we    = grant_b ? bus.b_we    : bus.a_we;
    assign sel_addr  = grant_b ? bus.b_addr  : bus.a_addr;
    assign sel_wdata = grant_b ? bus.b_wdata : bus.a_wdata;

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic plus memory strobes and requester responses.
    always_comb begin
        state_d          = state_q;
        bus.mem_memwrite = 1'b0;
        bus.mem_memread  = 1'b0;
        bus.a_ack        = 1'b0;
        bus.a_err        = 1'b0;
        bus.a_rdata      = 32'h0;
        bus.b_ack        = 1'b0;
        bus.b_err        = 1'b0;
        bus.b_rdata      = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (any_req) state_d = ACCESS;
            end
            ACCESS: begin
                bus.mem_memwrite = cmd_we_q & ~cmd_err_q;
                bus.mem_memread  = ~cmd_we_q & ~cmd_err_q;
                state_d          = RESP;
            end
            RESP: begin
                if (owner_b_q) begin
                    bus.b_ack   = 1'b1;
                    bus.b_err   = cmd_err_q;
                    bus.b_rdata = rdata_q;
                end else begin
                    bus.a_ack   = 1'b1;
                    bus.a_err   = cmd_err_q;
                    bus.a_rdata = rdata_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the winner's command at grant and the read data at the end of ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b_q    <= 1'b1;
            owner_b_q   <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= 32'h0;
            cmd_wdata_q <= 32'h0;
            cmd_err_q   <= 1'b0;
            rdata_q     <= 32'h0;
        end else begin
            if (state_q == IDLE && any_req) begin
                last_b_q    <= grant_b;
                owner_b_q   <= grant_b;
                cmd_we_q    <= sel_we;
                cmd_addr_q  <= sel_addr;
                cmd_wdata_q <= sel_wdata;
                cmd_err_q   <= addr_bad(sel_addr);
            end
            if (state_q == ACCESS) begin
                rdata_q <= (cmd_we_q || cmd_err_q) ? 32'h0 : bus.mem_rdata;
            end
        end
    end

    assign bus.mem_addr  = cmd_addr_q;
    assign bus.mem_wdata = cmd_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256-word data memory.
module tb_dmem_arbiter;

    logic clk;
    logic rst_n;
    logic preload;
    int   n_vec;
    int   n_err;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.MEM_AW(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory: synchronous write, combinational read.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[2] <= 32'h2;   // byte address 0x08
            mem[5] <= 32'h5;   // byte address 0x14
        end else if (bus.mem_memwrite) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_a_ack", {31'b0, bus.a_ack}, 32'h0);
        chk("rst_memwrite", {31'b0, bus.mem_memwrite}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One transaction from IDLE; leaves the arbiter back in IDLE.
    task automatic do_txn(input string tag, input logic is_b, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        logic exp_wr;
        logic exp_rd;
        exp_wr = we & ~exp_err;
        exp_rd = ~we & ~exp_err;
        if (is_b) begin
            bus.b_req = 1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
        end else begin
            bus.a_req = 1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
        end
        tick();  // granted, now ACCESS
        chk({tag, "_memwrite"}, {31'b0, bus.mem_memwrite}, {31'b0, exp_wr});
        chk({tag, "_memread"}, {31'b0, bus.mem_memread}, {31'b0, exp_rd});
        chk({tag, "_early_ack"}, {30'b0, bus.a_ack, bus.b_ack}, 32'h0);
        if (!exp_err) chk({tag, "_mem_addr"}, bus.mem_addr, addr);
        tick();  // RESP
        chk({tag, "_memwrite_resp"}, {31'b0, bus.mem_memwrite}, 32'h0);
        if (is_b) begin
            chk({tag, "_ack"}, {30'b0, bus.a_ack, bus.b_ack}, 32'h1);
            chk({tag, "_rdata"}, bus.b_rdata, exp_rdata);
            chk({tag, "_err"}, {31'b0, bus.b_err}, {31'b0, exp_err});
            chk({tag, "_other_rdata"}, bus.a_rdata, 32'h0);
        end else begin
            chk({tag, "_ack"}, {30'b0, bus.a_ack, bus.b_ack}, 32'h2);
            chk({tag, "_rdata"}, bus.a_rdata, exp_rdata);
            chk({tag, "_err"}, {31'b0, bus.a_err}, {31'b0, exp_err});
            chk({tag, "_other_rdata"}, bus.b_rdata, 32'h0);
        end
        idle_inputs();
        tick();  // back to IDLE
        chk({tag, "_ack_once"}, {30'b0, bus.a_ack, bus.b_ack}, 32'h0);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        preload = 1'b1;
        idle_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_acks", {30'b0, bus.a_ack, bus.b_ack}, 32'h0);
        chk("rst_strobes", {30'b0, bus.mem_memwrite, bus.mem_memread}, 32'h0);
        chk("rst_rdata", bus.a_rdata | bus.b_rdata, 32'h0);
        tick();
        preload = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // B read of preloaded word with A idle
        do_txn("b_rd14", 1'b1, 1'b0, 32'h14, 32'h0, 32'h5, 1'b0);

        // A write then read back
        do_txn("a_wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        do_txn("a_rd10", 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // B error cases: misaligned, out of range, misaligned write
        do_txn("b_mis", 1'b1, 1'b0, 32'h0000_0402, 32'h0, 32'h0, 1'b1);
        do_txn("b_oor", 1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h0, 1'b1);
        do_txn("b_wmis", 1'b1, 1'b1, 32'h0000_0011, 32'h1234, 32'h0, 1'b1);
        do_txn("a_rd10b", 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        do_txn("a_last", 1'b0, 1'b0, 32'h3FC, 32'h0, 32'h0, 1'b0);

        // Reset pulsed during ACCESS drops the write
        bus.a_req = 1; bus.a_we = 1; bus.a_addr = 32'h8; bus.a_wdata = 32'h55;
        tick();
        chk("rstmid_memwrite_pre", {31'b0, bus.mem_memwrite}, 32'h1);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rstmid_memwrite", {31'b0, bus.mem_memwrite}, 32'h0);
        chk("rstmid_mem_addr", bus.mem_addr, 32'h0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("rstmid_noack1", {30'b0, bus.a_ack, bus.b_ack}, 32'h0);
        tick();
        chk("rstmid_noack2", {30'b0, bus.a_ack, bus.b_ack}, 32'h0);
        do_txn("a_rd8", 1'b0, 1'b0, 32'h8, 32'h0, 32'h2, 1'b0);

        // Both requesting continuously from reset: A, B, A, B
        do_reset();
        bus.a_req = 1; bus.a_we = 0; bus.a_addr = 32'h14;
        bus.b_req = 1; bus.b_we = 0; bus.b_addr = 32'h8;
        for (int k = 0; k < 4; k++) begin
            tick();  // ACCESS
            chk("rr_access_acks", {30'b0, bus.a_ack, bus.b_ack}, 32'h0);
            tick();  // RESP
            if (k % 2 == 0) begin
                chk("rr_ack_a", {30'b0, bus.a_ack, bus.b_ack}, 32'h2);
                chk("rr_rdata_a", bus.a_rdata, 32'h5);
            end else begin
                chk("rr_ack_b", {30'b0, bus.a_ack, bus.b_ack}, 32'h1);
                chk("rr_rdata_b", bus.b_rdata, 32'h2);
            end
            tick();  // IDLE
            chk("rr_idle_acks", {30'b0, bus.a_ack, bus.b_ack}, 32'h0);
        end
        idle_inputs();
        tick();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout: got %0d expected %0d", 1, 0);
        $fatal(1);
    end

endmodule
